// File: rtl/inst_fetch_resp_if.sv
// Instruction-fetch memory read bus.
//
// Handshake: the fetch unit (master) holds mem_req high with a stable
// mem_addr until the memory (slave) pulses mem_ack for one cycle. mem_rdata
// is valid in that same cycle. There is no separate ready signal, and
// mem_ack while mem_req is low carries no meaning.
//
// Signals:
//   mem_req   master -> slave  read request
//   mem_addr  master -> slave  word-aligned read address
//   mem_ack   slave  -> master read completion
//   mem_rdata slave  -> master read data, valid with mem_ack
interface inst_fetch_resp_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/inst_fetch_resp.sv
// Instruction fetch response stage: a small direct-mapped instruction buffer
// in front of a simple request/acknowledge memory port.
//
// A hit returns the buffered word in the same cycle. A miss on an aligned pc
// issues one memory read and stalls the pipeline until it completes or times
// out. A misaligned pc never goes to memory; it fills the entry with zero and
// raises the sticky fetch_err.
//
// Build option: define IF_LINEBUF_EN for a four-entry buffer (index pc[3:2],
// tag pc[31:4]). Without it the buffer holds a single word (tag pc[31:2]).
//
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   pc, ce      fetch address and fetch enable from the PC stage
//   inst        instruction for pc (zero unless inst_valid)
//   inst_valid  inst belongs to the current pc this cycle
//   stallreq    hold the PC stage
//   fetch_err   sticky error (timeout or misaligned pc), cleared by reset
//   dbg_state   FSM state: 0 = IDLE, 1 = REQ
//   mem         memory read bus (master side)
// Parameter:
//   TIMEOUT     REQ cycles to wait for mem_ack before abandoning (1..65535)
module inst_fetch_resp #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pc,
    input  logic              ce,
    output logic [31:0]       inst,
    output logic              inst_valid,
    output logic              stallreq,
    output logic              fetch_err,
    output logic              dbg_state,
    inst_fetch_resp_if.master mem
);

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

`ifdef IF_LINEBUF_EN
    localparam int ENTRIES = 4;
    localparam int IDX_W   = 2;
    localparam int TAG_W   = 28;
`else
    localparam int ENTRIES = 1;
    localparam int IDX_W   = 1;
    localparam int TAG_W   = 30;
`endif

    // The counter starts at 0 on entry to REQ, so leaving at TIMEOUT-1 gives
    // exactly TIMEOUT cycles with mem_req high.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t             state;
    logic [15:0]        cnt;
    logic [31:0]        req_addr;
    logic [ENTRIES-1:0] buf_valid;
    logic [TAG_W-1:0]   buf_tag  [ENTRIES];
    logic [31:0]        buf_data [ENTRIES];

    logic [IDX_W-1:0]   pc_idx;
    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   pc_tag;
    logic [TAG_W-1:0]   req_tag;

`ifdef IF_LINEBUF_EN
    assign pc_idx  = pc[3:2];
    assign pc_tag  = pc[31:4];
    assign req_idx = req_addr[3:2];
    assign req_tag = req_addr[31:4];
`else
    assign pc_idx  = 1'b0;
    assign pc_tag  = pc[31:2];
    assign req_idx = 1'b0;
    assign req_tag = req_addr[31:2];
`endif

    logic hit;
    logic miss;
    logic misaligned;

    assign hit        = ce && buf_valid[pc_idx] && (buf_tag[pc_idx] == pc_tag);
    assign miss       = ce && !hit;
    assign misaligned = (pc[1:0] != 2'b00);

    // Buffer fill: a completed or abandoned fetch in REQ, or the zero fill
    // of a misaligned miss in IDLE. Nothing is written while in reset, which
    // also drops a late mem_ack that arrives with rst.
    logic             fill_en;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic [31:0]      fill_data;

    always_comb begin
        fill_en   = 1'b0;
        fill_idx  = pc_idx;
        fill_tag  = pc_tag;
        fill_data = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (miss && misaligned) fill_en = 1'b1;
                end
                REQ: begin
                    fill_idx = req_idx;
                    fill_tag = req_tag;
                    if (mem.mem_ack) begin
                        fill_en   = 1'b1;
                        fill_data = mem.mem_rdata;
                    end else if (cnt == CNT_LAST) begin
                        fill_en = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Entry tag/data carry no reset; the valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            buf_tag[fill_idx]  <= fill_tag;
            buf_data[fill_idx] <= fill_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_addr  <= '0;
            buf_valid <= '0;
            fetch_err <= 1'b0;
        end else begin
            if (fill_en) buf_valid[fill_idx] <= 1'b1;
            case (state)
                IDLE: begin
                    if (miss) begin
                        if (!misaligned) begin
                            req_addr <= pc;
                            cnt      <= '0;
                            state    <= REQ;
                        end else begin
                            fetch_err <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // req_addr is frozen here, so pc changes cannot
                    // redirect the outstanding fetch.
                    if (mem.mem_ack) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        fetch_err <= 1'b1;
                        state     <= IDLE;
                    end else if (cnt != 16'hFFFF) begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem.mem_req  = (state == REQ);
    assign mem.mem_addr = (state == REQ) ? req_addr : 32'h0000_0000;
    assign inst_valid   = (state == IDLE) && hit;
    assign inst         = inst_valid ? buf_data[pc_idx] : 32'h0000_0000;
    assign stallreq     = (state == REQ) || miss;
    assign dbg_state    = (state == REQ);

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Bench for inst_fetch_resp: directed scenarios followed by random traffic,
// every cycle compared against a cycle-level reference model of the fetch
// buffer kept in plain arrays.
module tb_inst_fetch_resp;

    localparam int unsigned TB_TIMEOUT = 4;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        ce;
    logic [31:0] inst;
    logic        inst_valid;
    logic        stallreq;
    logic        fetch_err;
    logic        dbg_state;

    inst_fetch_resp_if mem_bus ();

    inst_fetch_resp #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .ce         (ce),
        .inst       (inst),
        .inst_valid (inst_valid),
        .stallreq   (stallreq),
        .fetch_err  (fetch_err),
        .dbg_state  (dbg_state),
        .mem        (mem_bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A fetch is either outstanding (m_busy, with its address and the number
    // of request cycles already spent) or not; the buffer is a set of
    // {valid, tag, data} slots.
    logic        m_busy;
    logic [31:0] m_addr;
    int          m_wait;
    logic        m_err;
    logic        m_valid [4];
    logic [31:0] m_tag   [4];
    logic [31:0] m_data  [4];

    function automatic int idx_of(input logic [31:0] a);
`ifdef IF_LINEBUF_EN
        return int'(a[3:2]);
`else
        return 0;
`endif
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
`ifdef IF_LINEBUF_EN
        return a >> 4;
`else
        return a >> 2;
`endif
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5a3c, ~a[15:0]};
    endfunction

    task automatic model_fill(input logic [31:0] a, input logic [31:0] d);
        m_valid[idx_of(a)] = 1'b1;
        m_tag[idx_of(a)]   = tag_of(a);
        m_data[idx_of(a)]  = d;
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_addr = '0;
        m_wait = 0;
        m_err  = 1'b0;
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    endtask

    // ---------------- driver: one clock cycle ----------------
    // Inputs change after the falling edge; outputs are compared 1 ns later,
    // then the model advances to what the next rising edge should produce.
    task automatic cycle(input logic r, input logic c, input logic [31:0] p,
                         input logic a, input logic [31:0] d, input bit do_chk);
        logic        hit;
        int          i;
        @(negedge clk);
        cyc++;
        rst               = r;
        ce                = c;
        pc                = p;
        mem_bus.mem_ack   = a;
        mem_bus.mem_rdata = d;
        #1;
        i   = idx_of(p);
        hit = c && m_valid[i] && (m_tag[i] == tag_of(p));
        if (do_chk) begin
            if (m_busy) begin
                check("mem_req",    {31'd0, mem_bus.mem_req}, 32'd1);
                check("mem_addr",   mem_bus.mem_addr, m_addr);
                check("stallreq",   {31'd0, stallreq},   32'd1);
                check("inst_valid", {31'd0, inst_valid}, 32'd0);
                check("inst",       inst, 32'd0);
            end else begin
                check("mem_req",    {31'd0, mem_bus.mem_req}, 32'd0);
                check("mem_addr",   mem_bus.mem_addr, 32'd0);
                check("stallreq",   {31'd0, stallreq},   {31'd0, c && !hit});
                check("inst_valid", {31'd0, inst_valid}, {31'd0, hit});
                check("inst",       inst, hit ? m_data[i] : 32'd0);
            end
            check("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
        end
        // next state
        if (r) begin
            model_reset();
        end else if (m_busy) begin
            if (a) begin
                model_fill(m_addr, d);
                m_busy = 1'b0;
            end else if (m_wait + 1 == int'(TB_TIMEOUT)) begin
                model_fill(m_addr, 32'd0);
                m_err  = 1'b1;
                m_busy = 1'b0;
            end else begin
                m_wait++;
            end
        end else if (c && !hit) begin
            if (p[1:0] == 2'b00) begin
                m_busy = 1'b1;
                m_addr = p;
                m_wait = 0;
            end else begin
                model_fill(p, 32'd0);
                m_err = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    int          n_req;
    logic [31:0] rpc;
    logic        rce;
    logic        rack;
    logic        rrst;

    initial begin
        rst = 1'b1; ce = 1'b0; pc = '0;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0;
        end
        model_reset();

        // power-up: first reset cycle unchecked (state unknown before edge)
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        do_reset();

        // basic miss, ack in first request cycle
        cycle(1'b0, 1'b1, 32'h0, 1'b0, 32'd0, 1'b1);
        cycle(1'b0, 1'b1, 32'h0, 1'b1, 32'h34011100, 1'b1);
        cycle(1'b0, 1'b1, 32'h0, 1'b0, 32'd0, 1'b1);
        check("first_inst", inst, 32'h34011100);

        // timeout: mem_req high for exactly TIMEOUT cycles
        do_reset();
        n_req = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b1, 32'h100, 1'b0, 32'hdead_beef, 1'b1);
            if (mem_bus.mem_req) n_req++;
        end
        check("timeout_req_cycles", n_req, TB_TIMEOUT);

        // misaligned pc: no request at all
        do_reset();
        n_req = 0;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b1, 32'h6, 1'b0, 32'd0, 1'b1);
            if (mem_bus.mem_req) n_req++;
        end
        check("misaligned_req_cycles", n_req, 0);

        // fetch 0x0, 0x4, 0x8 then return to 0x4; spurious ack while idle
        do_reset();
        for (int w = 0; w < 3; w++) begin
            cycle(1'b0, 1'b1, 32'(w * 4), 1'b1, 32'hffff_ffff, 1'b1);
            cycle(1'b0, 1'b1, 32'(w * 4), 1'b1, mem_word(32'(w * 4)), 1'b1);
        end
        cycle(1'b0, 1'b1, 32'h4, 1'b0, 32'd0, 1'b1);
        cycle(1'b0, 1'b1, 32'h4, 1'b1, mem_word(32'h4), 1'b1);
        cycle(1'b0, 1'b1, 32'h4, 1'b0, 32'd0, 1'b1);

        // pc changes while a fetch is outstanding
        cycle(1'b0, 1'b1, 32'h40, 1'b0, 32'd0, 1'b1);
        cycle(1'b0, 1'b1, 32'h80, 1'b0, 32'd0, 1'b1);
        cycle(1'b0, 1'b0, 32'hc0, 1'b1, mem_word(32'h40), 1'b1);
        cycle(1'b0, 1'b1, 32'h40, 1'b0, 32'd0, 1'b1);

        // reset during a request, late ack must not fill
        cycle(1'b0, 1'b1, 32'h20, 1'b0, 32'd0, 1'b1);
        cycle(1'b1, 1'b1, 32'h20, 1'b0, 32'd0, 1'b1);
        cycle(1'b0, 1'b0, 32'h20, 1'b1, 32'h1234_5678, 1'b1);
        cycle(1'b0, 1'b1, 32'h20, 1'b0, 32'd0, 1'b1);
        check("post_reset_refetch", {31'd0, mem_bus.mem_req}, 32'd0);
        cycle(1'b0, 1'b1, 32'h20, 1'b0, 32'd0, 1'b1);
        check("post_reset_req", {31'd0, mem_bus.mem_req}, 32'd1);
        cycle(1'b0, 1'b1, 32'h20, 1'b1, mem_word(32'h20), 1'b1);

        // ce low mid-sequence
        for (int k = 0; k < 3; k++)
            cycle(1'b0, 1'b0, 32'h300, 1'b0, 32'd0, 1'b1);

        // random traffic
        rpc = 32'h0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 99) < 30) begin
                if ($urandom_range(0, 99) < 5) rpc = 32'($urandom_range(0, 63));
                else rpc = 32'($urandom_range(0, 15) * 4);
            end
            rce  = ($urandom_range(0, 9) != 0);
            rrst = ($urandom_range(0, 199) == 0);
            if (m_busy) rack = ($urandom_range(0, 2) == 0);
            else        rack = ($urandom_range(0, 7) == 0);
            cycle(rrst, rce, rpc, rack,
                  m_busy ? mem_word(m_addr) : 32'($urandom), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/inst_fetch_resp.md
INST_FETCH_RESP -- requirements
Module: inst_fetch_resp

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning: maximum REQ-state cycles awaiting mem_ack before abandoning the fetch (range 1..65535).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high (`RstEnable = 1).
REQ-004 pc  input  32  fetch address from the PC stage.
REQ-005 ce  input  1  fetch enable from the PC stage; 1 = fetch requested.
REQ-006 inst  output  32  instruction for pc; combinational from stored data.
REQ-007 inst_valid  output  1  inst is valid for the current pc this cycle.
REQ-008 stallreq  output  1  stall request to the pipeline controller; PC stage holds pc while high.
REQ-009 mem_req  output  1  memory read request, registered-state driven.
REQ-010 mem_addr  output  32  word-aligned memory read address.
REQ-011 mem_ack  input  1  memory read completion; mem_rdata valid in same cycle.
REQ-012 mem_rdata  input  32  memory read data.
REQ-013 fetch_err  output  1  sticky error flag (timeout or misaligned pc).

Function
REQ-014 Storage SHALL be a direct-mapped instruction buffer of entries {valid, tag, data}; entry count fixed by REQ-034.
REQ-015 hit SHALL be: ce=1 and indexed entry valid and entry tag equals the pc tag field; miss = ce=1 and not hit.
REQ-016 FSM SHALL have exactly two states: IDLE and REQ.
REQ-017 IDLE: inst = indexed entry data when hit, else 32'h00000000; inst_valid = hit; stallreq = miss; mem_req = 0.
REQ-018 IDLE, miss, pc[1:0]=2'b00: capture req_addr = pc, clear timeout counter, go REQ at next edge.
REQ-019 IDLE, miss, pc[1:0]≠2'b00: no memory request; at next edge fill indexed entry with data 32'h00000000 and tag of pc, set fetch_err, stay IDLE (one stall cycle).
REQ-020 REQ: mem_req = 1, mem_addr = req_addr, stallreq = 1, inst_valid = 0, inst = 32'h00000000; mem_addr stable until exit.
REQ-021 REQ, mem_ack=1: at that edge write mem_rdata with tag/index of req_addr into the buffer, set valid, go IDLE; mem_req low the following cycle.
REQ-022 REQ, mem_ack=0: counter increments each cycle, 16-bit, saturating; when counter reaches TIMEOUT−1 without ack, fill entry with 32'h00000000, set fetch_err, go IDLE.
REQ-023 mem_ack while IDLE SHALL be ignored (no buffer write).
REQ-024 Minimum miss latency: miss visible cycle N, REQ in N+1, ack in N+1 → hit and inst_valid=1 in cycle N+2.
REQ-025 pc change during REQ SHALL NOT alter req_addr or the outstanding fetch; the fill goes to req_addr's entry.
REQ-026 ce=0: inst=0, inst_valid=0, stallreq=0 in IDLE; a REQ in progress completes normally.
REQ-027 fetch_err SHALL remain 1 until reset.

Reset
REQ-028 rst=1 at an edge: state→IDLE, all entry valid bits→0, counter→0, req_addr→0, fetch_err→0.
REQ-029 During and after reset: mem_req=0, mem_addr=0, stallreq=0 while ce=0, inst=0, inst_valid=0.
REQ-030 Reset in REQ SHALL drop mem_req the next cycle; a late mem_ack SHALL not write the buffer.
REQ-031 Entry data/tag need no reset; valid bits alone gate use.

Configuration
REQ-032 Macro IF_LINEBUF_EN selects buffer depth.
REQ-033 Without IF_LINEBUF_EN: one entry, tag = pc[31:2]; any pc change from the last filled word misses.
REQ-034 With IF_LINEBUF_EN: four entries, index = pc[3:2], tag = pc[31:4]; re-fetch of a resident word hits with no mem_req and no stall.

Verification
REQ-035 Reset, ce=1, pc=0x00000000, mem_ack one cycle after mem_req, rdata=0x34011100 -> stallreq 1 for 2 cycles, mem_addr=0x0, inst=0x34011100 with inst_valid in cycle 3.
REQ-036 Hold mem_ack=0, TIMEOUT=4 -> mem_req high exactly 4 cycles, then inst=0, inst_valid=1, fetch_err=1.
REQ-037 pc=0x00000006, ce=1 -> no mem_req, one stall cycle, inst=0, fetch_err=1.
REQ-038 With IF_LINEBUF_EN: fetch 0x0,0x4,0x8, then pc=0x4 -> inst_valid=1 same cycle, mem_req stays 0; without macro -> new mem_req to 0x4.
REQ-039 rst=1 in REQ, then mem_ack=1 next cycle -> mem_req 0, pc=req address misses after reset (new mem_req issued).
REQ-040 ce=0 mid-sequence -> inst=0, inst_valid=0, stallreq=0, no new mem_req.
